// File: rtl/krake_port_pkg.sv
// Shared constants and FSM state type for the krake port UART transmitter.
// KRAKE_UART_PARITY_EN adds the PARITY state for 8E1 framing.
package krake_port_pkg;
  localparam logic [4:0] UART_DATAREG = 5'h00;
  localparam logic [4:0] UART_STATUS  = 5'h01;
  localparam int         STAT_TX_RDY  = 0;

`ifdef KRAKE_UART_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
`endif
endpackage

// File: rtl/krake_uart_tx_core.sv
// UART serialiser: baud counter plus frame FSM, LSB first, TXD registered.
// KRAKE_UART_PARITY_EN inserts an even-parity bit before the stop bit.
//   state     | meaning
//   ST_IDLE   | line high, tx_rdy=1, baud counter held at 0
//   ST_START  | start bit (0)
//   ST_DATA   | data bit bit_idx (0..7)
//   ST_PARITY | even parity of the frame byte
//   ST_STOP   | stop bit (1); a start on its last cycle chains the next frame
module krake_uart_tx_core
  import krake_port_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tx_rdy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          txd_nx;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_rdy   = (state == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      bit_idx  <= bit_nx;
      shreg    <= shreg_nx;
      txd      <= txd_nx;
      baud_cnt <= (state == ST_IDLE || baud_end) ? '0 : baud_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    txd_nx   = txd;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_START;
          shreg_nx = data;
          txd_nx   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_nx = ST_DATA;
          bit_nx   = 3'd0;
          txd_nx   = shreg[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
`ifdef KRAKE_UART_PARITY_EN
            state_nx = ST_PARITY;
            txd_nx   = ^shreg;
`else
            state_nx = ST_STOP;
            txd_nx   = 1'b1;
`endif
          end else begin
            bit_nx = bit_idx + 3'd1;
            txd_nx = shreg[bit_idx + 3'd1];
          end
        end
      end
`ifdef KRAKE_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          state_nx = ST_STOP;
          txd_nx   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          if (start) begin
            state_nx = ST_START;
            shreg_nx = data;
            txd_nx   = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        txd_nx   = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/krake_port_tx_2.sv
// Wishbone-style register slave driving one UART TX on ch_out[0] of a krake port.
// Build option KRAKE_UART_PARITY_EN selects 8E1 framing in the core.
module krake_port_tx_2
  import krake_port_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [4:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic [5:0] ch_in,
  output logic [5:0] ch_out,
  output logic [5:0] ch_oe,
  input  logic       clka,
  input  logic       clkb,
  input  logic       clkc,
  input  logic       clkd
);
  logic [7:0] datareg;
  logic [7:0] status;
  logic       tx_rdy;
  logic       txd;
  logic       start;
  logic       unused_in;

  // Reserved pins and aux clocks are intentionally left unconnected.
  assign unused_in = ^{ch_in, clka, clkb, clkc, clkd};

  // Core ignores start while a frame is in flight, so no busy gating here.
  assign start = stb_i & we_i & (adr_i == UART_STATUS) & dat_i[0];

  always_comb begin
    status              = '0;
    status[STAT_TX_RDY] = tx_rdy;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      datareg <= '0;
      ack_o   <= 1'b0;
      dat_o   <= '0;
    end else begin
      ack_o <= stb_i;
      if (stb_i && we_i && adr_i == UART_DATAREG) datareg <= dat_i;
      if (stb_i) begin
        if (we_i) begin
          dat_o <= '0;
        end else begin
          case (adr_i)
            UART_DATAREG: dat_o <= datareg;
            UART_STATUS:  dat_o <= status;
            default:      dat_o <= '0;
          endcase
        end
      end
    end
  end

  krake_uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (start),
    .data   (datareg),
    .txd    (txd),
    .tx_rdy (tx_rdy)
  );

  assign ch_out = {5'b0, txd};
  assign ch_oe  = 6'b000001;
endmodule

// File: tb/tb_krake_port_tx_2.sv
// Scoreboard bench for krake_port_tx_2 with BAUD_DIV=4: bus reads and TXD frames
// are queued as expectations by the stimulus and checked by independent monitors.
module tb_krake_port_tx_2;
  localparam int B = 4;
`ifdef KRAKE_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic [4:0] adr_i = '0;
  logic [7:0] dat_i = '0;
  logic [7:0] dat_o;
  logic       ack_o;
  logic [5:0] ch_in = '0;
  logic [5:0] ch_out;
  logic [5:0] ch_oe;
  logic       clka = 1'b0, clkb = 1'b0, clkc = 1'b0, clkd = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic rd; logic [7:0] data; } bus_exp_t;
  bus_exp_t    bus_q[$];
  logic [10:0] frame_q[$];

  krake_port_tx_2 #(.BAUD_DIV(B)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .ch_in(ch_in), .ch_out(ch_out),
    .ch_oe(ch_oe), .clka(clka), .clkb(clkb), .clkc(clkc), .clkd(clkd)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef KRAKE_UART_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d;
    bus_q.push_back({~we, exp});
    @(negedge clk_i);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus(1'b1, 5'h00, b, 8'h00);
    frame_q.push_back(mk_frame(b));
    bus(1'b1, 5'h01, 8'h01, 8'h00);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dut.tx_rdy !== 1'b1 && n < 20 * B * NBITS) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_idle_timeout", {31'b0, dut.tx_rdy}, 32'd1);
  endtask

  // Bus monitor: every ack consumes one expectation; reads compare dat_o.
  always @(negedge clk_i) begin
    if (ack_o === 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ack: ack with no access pending");
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        if (e.rd) check("read_data", {24'b0, dat_o}, {24'b0, e.data});
      end
    end
  end

  // TXD monitor: samples near each bit centre; frames hit by reset are dropped.
  logic [10:0] mon_got;
  logic        mon_abort;
  logic [10:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1 && ch_out[0] === 1'b0) begin
        mon_got = '1;
        mon_abort = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
          for (int k = 0; k < ((i == 0) ? B / 2 : B); k++) begin
            @(negedge clk_i);
            if (rst_i !== 1'b1) mon_abort = 1'b1;
          end
          mon_got[i] = ch_out[0];
        end
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got %0h with none expected", mon_got);
        end else begin
          mon_exp = frame_q.pop_front();
          if (!mon_abort) check("txd_frame", {21'b0, mon_got}, {21'b0, mon_exp});
        end
      end
    end
  end

  int low_cnt;

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_txd", {26'b0, ch_out}, 32'h01);
    check("rst_oe", {26'b0, ch_oe}, 32'h01);
    check("rst_tx_rdy", {31'b0, dut.tx_rdy}, 32'd1);
    check("rst_ack", {31'b0, ack_o}, 32'd0);

    bus(1'b0, 5'h01, 8'h00, 8'h01);
    bus(1'b0, 5'h00, 8'h00, 8'h00);
    bus(1'b1, 5'h00, 8'hAA, 8'h00);
    bus(1'b0, 5'h00, 8'h00, 8'hAA);
    bus(1'b0, 5'h1F, 8'h00, 8'h00);
    bus(1'b1, 5'h1F, 8'hFF, 8'h00);
    bus(1'b0, 5'h00, 8'h00, 8'hAA);

    // Frame 0xAA, status must read busy on the next access.
    frame_q.push_back(mk_frame(8'hAA));
    bus(1'b1, 5'h01, 8'h01, 8'h00);
    bus(1'b0, 5'h01, 8'h00, 8'h00);
    wait_idle();
    bus(1'b0, 5'h01, 8'h00, 8'h01);

    // Frame 0x0F with exact busy-length measurement.
    send(8'h0F);
    low_cnt = 0;
    while (dut.tx_rdy === 1'b0 && low_cnt < 1000) begin
      low_cnt++;
      @(negedge clk_i);
    end
    check("busy_clocks", low_cnt, NBITS * B);

    // Data rewrite and repeated start while busy leave the frame alone.
    send(8'h33);
    bus(1'b1, 5'h00, 8'h55, 8'h00);
    bus(1'b1, 5'h01, 8'h01, 8'h00);
    bus(1'b0, 5'h00, 8'h00, 8'h55);
    wait_idle();
    repeat (12 * B) @(negedge clk_i);
    check("single_frame", frame_q.size(), 0);
    check("idle_after_ignored_start", {31'b0, dut.tx_rdy}, 32'd1);

    // Reset mid-frame.
    send(8'hC3);
    repeat (10) @(negedge clk_i);
    check("busy_before_reset", {31'b0, dut.tx_rdy}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_txd", {31'b0, ch_out[0]}, 32'd1);
    check("abort_tx_rdy", {31'b0, dut.tx_rdy}, 32'd1);
    check("abort_datareg", {24'b0, dut.datareg}, 32'd0);
    rst_i = 1'b1;
    repeat (NBITS * B + 8) @(negedge clk_i);
    bus(1'b0, 5'h00, 8'h00, 8'h00);

`ifdef KRAKE_UART_PARITY_EN
    send(8'h07);
    wait_idle();
    repeat (4) @(negedge clk_i);
`endif

    repeat (4) @(negedge clk_i);
    check("bus_q_drained", bus_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
